// File: rtl/acc_drain_ctrl_if.sv
// rtl/acc_drain_ctrl_if.sv - accumulator read port and unified-buffer row stream
interface acc_drain_ctrl_if #(
    parameter int DOUT_WIDTH = 128,
    parameter int ACC_ADDR_W = 6,
    parameter int UB_ADDR_W  = 8
);
    logic                  acc_enb;
    logic [ACC_ADDR_W-1:0] acc_addrb;
    logic [DOUT_WIDTH-1:0] acc_doutb;
    logic                  m_valid;
    logic                  m_ready;
    logic [DOUT_WIDTH-1:0] m_data;
    logic [UB_ADDR_W-1:0]  m_addr;

    modport master (
        output acc_enb, acc_addrb,
        input  acc_doutb,
        output m_valid, m_data, m_addr,
        input  m_ready
    );

    modport slave (
        input  acc_enb, acc_addrb,
        output acc_doutb,
        input  m_valid, m_data, m_addr,
        output m_ready
    );
endinterface

// File: rtl/acc_drain_ctrl.sv
// rtl/acc_drain_ctrl.sv - drains accumulator rows into the unified-buffer write stream
module acc_drain_ctrl #(
    parameter int DOUT_WIDTH = 128,
    parameter int RAM_DEPTH  = 64,
    parameter int ACC_ADDR_W = 6,
    parameter int UB_ADDR_W  = 8,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ACC_ADDR_W-1:0] acc_base,
    input  logic [ACC_ADDR_W:0]   row_cnt,
    input  logic [UB_ADDR_W-1:0]  ub_base,
    output logic                  busy,
    output logic                  done,
    acc_drain_ctrl_if.master      bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [ACC_ADDR_W:0]   rd_left, pop_left;
    logic [ACC_ADDR_W-1:0] rd_addr;
    logic [UB_ADDR_W-1:0]  push_addr;
    logic                  in_flight;
    logic [1:0]            occ, wr_ptr, rd_ptr;
    logic [DOUT_WIDTH-1:0] fifo_data [0:FIFO_DEPTH-1];
    logic [UB_ADDR_W-1:0]  fifo_addr [0:FIFO_DEPTH-1];
    logic                  rd_en, push, pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign push = in_flight;
    assign pop  = bus.m_valid && bus.m_ready;

    // A read is only issued when a FIFO slot is reserved for it; a same-cycle pop does not free one.
    assign rd_en = (state == READ) && (rd_left != '0) &&
                   (({1'b0, occ} + {2'b00, in_flight}) < 3'd3);

    assign bus.acc_enb   = rd_en;
    assign bus.acc_addrb = rd_addr;
    assign bus.m_valid   = (occ != 2'd0);
    assign bus.m_data    = fifo_data[rd_ptr];
    assign bus.m_addr    = fifo_addr[rd_ptr];

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (row_cnt != '0) ? READ : DONE;
            end
            READ: begin
                busy = 1'b1;
                if (rd_en && rd_left == (ACC_ADDR_W+1)'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && pop_left == (ACC_ADDR_W+1)'(1)) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rd_left   <= '0;
            pop_left  <= '0;
            rd_addr   <= '0;
            push_addr <= '0;
            in_flight <= 1'b0;
            occ       <= 2'd0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            in_flight <= rd_en;
            if (state == IDLE && start) begin
                rd_left   <= row_cnt;
                pop_left  <= row_cnt;
                rd_addr   <= acc_base;
                push_addr <= ub_base;
            end
            if (rd_en) begin
                rd_left <= rd_left - 1'b1;
                rd_addr <= (rd_addr == ACC_ADDR_W'(RAM_DEPTH-1)) ? '0 : rd_addr + 1'b1;
            end
            if (push) begin
                fifo_data[wr_ptr] <= bus.acc_doutb;
                fifo_addr[wr_ptr] <= push_addr;
                wr_ptr            <= ptr_inc(wr_ptr);
                push_addr         <= push_addr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= ptr_inc(rd_ptr);
                pop_left <= pop_left - 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_drain_ctrl.sv
// tb/tb_acc_drain_ctrl.sv - directed bench with row-sequence scoreboard for acc_drain_ctrl
module tb_acc_drain_ctrl;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [5:0]   acc_base;
    logic [6:0]   row_cnt;
    logic [7:0]   ub_base;
    logic         busy, done;

    acc_drain_ctrl_if #(.DOUT_WIDTH(128), .ACC_ADDR_W(6), .UB_ADDR_W(8)) bus ();

    acc_drain_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .acc_base (acc_base),
        .row_cnt  (row_cnt),
        .ub_base  (ub_base),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [127:0] mem [0:63];
    always @(posedge clk) if (bus.acc_enb) bus.acc_doutb <= mem[bus.acc_addrb];

    typedef struct { logic [127:0] d; logic [7:0] a; } row_t;
    row_t exp_q[$];

    int checks = 0, errors = 0;
    bit active, done_due, prev_stall;
    int rd_left, issued, popped, drain_n, rel;
    logic [5:0] rd_addr_exp, last_rd;
    logic [127:0] held_d;
    logic [7:0] held_a, first_addr;
    int first_enb, first_valid, done_rel, enb_by9, enb_total;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        active = 0; done_due = 0; prev_stall = 0;
        rd_left = 0; issued = 0; popped = 0; drain_n = 0;
        exp_q.delete();
    endtask

    // Sampled at negedge: expected outputs follow from the drained row sequence and the 3-row limit.
    task automatic model_check();
        bit accept, done_now;
        row_t r;
        if (!reset_n) begin
            clear_model();
            return;
        end
        rel++;
        chk("busy", busy, active);
        chk("done", done, done_due);
        if (done) done_rel = rel;
        done_now = done_due;
        done_due = 0;
        if (!active) chk("m_valid_idle", bus.m_valid, 0);
        if (bus.acc_enb) begin
            enb_total++;
            if (rel <= 9) enb_by9++;
            if (first_enb < 0) first_enb = rel;
            last_rd = bus.acc_addrb;
            if (rd_left == 0) begin
                errors++; checks++;
                $display("FAIL extra_read: acc_enb=1 at addr %0d, required 0", bus.acc_addrb);
            end else begin
                chk("acc_addrb", bus.acc_addrb, rd_addr_exp);
                chk("credit", (issued - popped) < 3, 1);
                rd_left--; issued++; rd_addr_exp++;
            end
        end
        if (prev_stall) begin
            chk("stall_valid", bus.m_valid, 1);
            chk("stall_data", bus.m_data, held_d);
            chk("stall_addr", bus.m_addr, held_a);
        end
        if (bus.m_valid && first_valid < 0) begin
            first_valid = rel;
            first_addr  = bus.m_addr;
        end
        if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL extra_row: got addr %0h, required no row", bus.m_addr);
            end else begin
                r = exp_q.pop_front();
                chk("m_data", bus.m_data, r.d);
                chk("m_addr", bus.m_addr, r.a);
                popped++;
                if (popped == drain_n) done_due = 1;
            end
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        held_d = bus.m_data;
        held_a = bus.m_addr;
        accept = start && !active;
        if (done_now) active = 0;
        if (accept) begin
            active = 1; rel = 0; drain_n = int'(row_cnt);
            rd_left = drain_n; issued = 0; popped = 0; rd_addr_exp = acc_base;
            first_enb = -1; first_valid = -1; done_rel = -1; enb_by9 = 0; enb_total = 0;
            exp_q.delete();
            for (int i = 0; i < drain_n; i++)
                exp_q.push_back('{mem[(int'(acc_base) + i) % 64], 8'((int'(ub_base) + i) % 256)});
            if (drain_n == 0) done_due = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #2;
    endtask

    task automatic run_drain(input int b, input int n, input int u,
                             input int stall_lo, input int stall_hi, input int ovr_at);
        bit fin = 0;
        start = 1; acc_base = 6'(b); row_cnt = 7'(n); ub_base = 8'(u); bus.m_ready = 1;
        for (int c = 1; c <= 300 && !fin; c++) begin
            tick();
            start = 0;
            bus.m_ready = !(c >= stall_lo && c <= stall_hi);
            if (c == ovr_at) begin
                start = 1; acc_base = 6'(b + 5); row_cnt = 7'd3; ub_base = 8'(u + 40);
            end
            if (done_rel >= 0 && !active) fin = 1;
        end
        start = 0;
        bus.m_ready = 1;
        if (!fin) begin
            errors++; checks++;
            $display("FAIL timeout: drain of %0d rows not done in 300 cycles", n);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        clear_model();
        rel = 0; first_enb = -1; first_valid = -1; done_rel = -1;
        reset_n = 0; start = 0; acc_base = 0; row_cnt = 0; ub_base = 0; bus.m_ready = 1;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_enb", bus.acc_enb, 0);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_addrb", bus.acc_addrb, 0);
        chk("rst_mdata", bus.m_data, 0);
        @(posedge clk); #2;
        reset_n = 1;
        tick(); tick();

        run_drain(0, 4, 8'h10, 0, -1, -1);
        chk("t1_first_enb", first_enb, 1);
        chk("t1_first_valid", first_valid, 3);
        chk("t1_first_maddr", first_addr, 8'h10);
        chk("t1_done_cycle", done_rel, 7);
        chk("t1_reads", enb_total, 4);

        run_drain(62, 4, 8'hFE, 0, -1, -1);
        chk("t2_last_addrb", last_rd, 6'd1);
        chk("t2_rows", popped, 4);

        run_drain(5, 8, 8'h20, 2, 9, -1);
        chk("t3_reads_by_c9", enb_by9, 3);
        chk("t3_rows", popped, 8);

        run_drain(7, 0, 8'h30, 0, -1, -1);
        chk("t4_reads", enb_total, 0);
        chk("t4_no_valid", first_valid < 0, 1);
        chk("t4_done_cycle", done_rel, 1);

        run_drain(20, 6, 8'h40, 0, -1, 3);
        chk("t5_rows", popped, 6);
        chk("t5_reads", enb_total, 6);
        tick(); tick();
        chk("t5_idle_busy", busy, 0);

        start = 1; acc_base = 6'd10; row_cnt = 7'd16; ub_base = 8'h50;
        tick();
        start = 0;
        tick(); tick(); tick();
        reset_n = 0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_enb", bus.acc_enb, 0);
        chk("t6_valid", bus.m_valid, 0);
        chk("t6_addrb", bus.acc_addrb, 0);
        chk("t6_mdata", bus.m_data, 0);
        chk("t6_maddr", bus.m_addr, 0);
        tick();
        reset_n = 1;
        tick(); tick();
        chk("t6_no_done", done_rel < 0, 1);
        run_drain(40, 16, 8'hF8, 6, 8, -1);
        chk("t6_rows", popped, 16);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
